ivl_uvm_ovl_win_stim_gen: RTL and testbench
===========================================

IVL_UVM_OVL_WIN_STIM_GEN -- requirements
Module: ivl_uvm_ovl_win_stim_gen

Interface
REQ-001 Parameter WIDTH, default 4, width of the generated test_expr bus.
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles inserted after each window before the next command is accepted (range 0..255).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high permits acceptance of new commands.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  generator can accept a command.
REQ-008 cmd_data  input  WIDTH  value to hold on test_expr across the window.
REQ-009 cmd_len  input  8  number of HOLD cycles between the start_event and end_event cycles.
REQ-010 cmd_inject  input  1  request one value change inside the window (violation).
REQ-011 cmd_inject_at  input  8  HOLD-cycle index (0-based) at which the change is applied.
REQ-012 start_event  output  1  window-open pulse to the checker.
REQ-013 end_event  output  1  window-close pulse to the checker.
REQ-014 test_expr  output  WIDTH  monitored expression driven to the checker.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a window and its gap finish.
REQ-017 expect_fire  output  1  valid with done; high when the finished window contained an injected change.
REQ-018 win_count  output  16  completed-window count.

Function
REQ-019 FSM states SHALL be IDLE, START, HOLD, END, GAP; all outputs registered.
REQ-020 cmd_ready SHALL be high only in IDLE with enable high; a command is accepted on a cycle with cmd_valid and cmd_ready both high, and cmd_* fields are captured that cycle.
REQ-021 Accept cycle -> START next cycle: start_event=1 for exactly one cycle, test_expr=captured cmd_data.
REQ-022 START -> HOLD when captured cmd_len>0; START -> END when cmd_len=0 (start and end pulses on consecutive cycles).
REQ-023 HOLD SHALL last exactly cmd_len cycles, tracked by an 8-bit down-counter; test_expr holds cmd_data.
REQ-024 When cmd_inject=1 and cmd_inject_at<cmd_len, test_expr SHALL equal cmd_data with bit 0 inverted from HOLD index cmd_inject_at through the END cycle inclusive.
REQ-025 When cmd_inject_at>=cmd_len or cmd_inject=0, no change SHALL be applied and expect_fire SHALL be 0 for that window.
REQ-026 END: end_event=1 for exactly one cycle; test_expr keeps its HOLD value; then -> GAP.
REQ-027 GAP: test_expr=0 for GAP_CYCLES cycles; with GAP_CYCLES=0, GAP lasts zero cycles and done is issued on the cycle after END.
REQ-028 done and expect_fire SHALL pulse on the final GAP cycle's successor (first IDLE cycle); expect_fire is 0 whenever done is 0.
REQ-029 win_count SHALL increment with each done pulse and saturate at 16'hFFFF.
REQ-030 enable going low mid-window SHALL NOT abort the window; it only blocks the next acceptance.
REQ-031 start_event and end_event SHALL never be high in the same cycle.
REQ-032 cmd_* changes while busy SHALL be ignored.

Reset
REQ-033 reset low SHALL immediately force state IDLE, counters 0, start_event=0, end_event=0, test_expr=0, busy=0, done=0, expect_fire=0, win_count=0, independent of clock.
REQ-034 Reset asserted mid-window SHALL discard the window with no done pulse; cmd_ready rises on the first clock edge after reset release when enable=1.

Verification
REQ-035 Clean window: cmd_data=4'b0101, cmd_len=3, inject=0, GAP_CYCLES=2 -> start_event at T+1, test_expr=0101 T+1..T+5, end_event at T+5, done at T+8 with expect_fire=0, win_count=1.
REQ-036 Injected window: cmd_data=4'b1001, cmd_len=4, inject=1, inject_at=2 -> test_expr 1001 for START and HOLD 0-1, 1000 from HOLD 2 through END, done with expect_fire=1.
REQ-037 Boundary: cmd_len=0 -> start_event and end_event on consecutive cycles; inject=1, inject_at=5, cmd_len=5 -> no change, expect_fire=0.
REQ-038 Back-to-back: cmd_valid held high with enable=1 for 3 commands -> 3 non-overlapping windows separated by GAP_CYCLES zeros, win_count=3, never start_event&&end_event.
REQ-039 Reset mid-HOLD: reset low at HOLD index 1 -> all outputs 0 asynchronously, no done, win_count unchanged at 0; next command after release runs normally.
REQ-040 Enable drop: enable low during HOLD -> window completes with done; cmd_ready stays 0 until enable returns high.

Source files
------------

// File: rtl/ivl_uvm_ovl_win_stim_gen.sv
// ivl_uvm_ovl_win_stim_gen
// Stimulus generator for a window-style assertion checker. Each accepted command
// opens a window: a one-cycle start_event, cmd_len HOLD cycles with test_expr held
// at cmd_data, a one-cycle end_event, then GAP_CYCLES cycles with test_expr = 0.
// Optionally bit 0 of test_expr is inverted from a chosen HOLD index through END,
// which the checker should flag as a violation.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              permits acceptance of new commands
//   cmd_valid/cmd_ready command handshake (ready only in IDLE with enable high)
//   cmd_data            value held on test_expr across the window
//   cmd_len             number of HOLD cycles
//   cmd_inject          request one bit-0 change inside the window
//   cmd_inject_at       HOLD index (0-based) where the change starts
//   start_event         window-open pulse
//   end_event           window-close pulse
//   test_expr           monitored expression
//   busy                high whenever not IDLE
//   done                one-cycle pulse in the first IDLE cycle after a window
//   expect_fire         valid with done; window contained an injected change
//   win_count           completed-window count, saturating
module ivl_uvm_ovl_win_stim_gen #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [7:0]       cmd_len,
   input  logic             cmd_inject,
   input  logic [7:0]       cmd_inject_at,
   output logic             start_event,
   output logic             end_event,
   output logic [WIDTH-1:0] test_expr,
   output logic             busy,
   output logic             done,
   output logic             expect_fire,
   output logic [15:0]      win_count
);

   typedef enum logic [2:0] {StIdle, StStart, StHold, StEnd, StGap} state_e;

   localparam logic [WIDTH-1:0] FlipMask = WIDTH'(1);
   localparam logic [7:0]       GapLast  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

   state_e           state_q;
   logic [WIDTH-1:0] data_q;
   logic [7:0]       cnt_q;       // remaining HOLD cycles, including the current one
   logic [7:0]       flip_cnt_q;  // cnt_q value at which the injected change starts
   logic             fire_q;
   logic [7:0]       gap_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         data_q      <= '0;
         cnt_q       <= '0;
         flip_cnt_q  <= '0;
         fire_q      <= 1'b0;
         gap_q       <= '0;
         cmd_ready   <= 1'b0;
         start_event <= 1'b0;
         end_event   <= 1'b0;
         test_expr   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         expect_fire <= 1'b0;
         win_count   <= '0;
      end else begin
         // Pulses default low; states below raise them for exactly one cycle.
         start_event <= 1'b0;
         end_event   <= 1'b0;
         done        <= 1'b0;
         expect_fire <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (cmd_valid && cmd_ready) begin
                  state_q     <= StStart;
                  data_q      <= cmd_data;
                  cnt_q       <= cmd_len;
                  fire_q      <= cmd_inject && (cmd_inject_at < cmd_len);
                  flip_cnt_q  <= cmd_len - cmd_inject_at;
                  cmd_ready   <= 1'b0;
                  start_event <= 1'b1;
                  test_expr   <= cmd_data;
                  busy        <= 1'b1;
               end else begin
                  cmd_ready <= enable;
               end
            end

            StStart: begin
               if (cnt_q != 8'd0) begin
                  state_q <= StHold;
                  // HOLD index 0 may already carry the injected change.
                  if (fire_q && (cnt_q == flip_cnt_q)) begin
                     test_expr <= data_q ^ FlipMask;
                  end
               end else begin
                  state_q   <= StEnd;
                  end_event <= 1'b1;
               end
            end

            StHold: begin
               if (cnt_q == 8'd1) begin
                  state_q   <= StEnd;
                  end_event <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
                  if (fire_q && ((cnt_q - 8'd1) == flip_cnt_q)) begin
                     test_expr <= data_q ^ FlipMask;
                  end
               end
            end

            StEnd: begin
               test_expr <= '0;
               if (GAP_CYCLES == 0) begin
                  state_q     <= StIdle;
                  busy        <= 1'b0;
                  cmd_ready   <= enable;
                  done        <= 1'b1;
                  expect_fire <= fire_q;
                  if (win_count != 16'hFFFF) win_count <= win_count + 16'd1;
               end else begin
                  state_q <= StGap;
                  gap_q   <= GapLast;
               end
            end

            StGap: begin
               if (gap_q == 8'd0) begin
                  state_q     <= StIdle;
                  busy        <= 1'b0;
                  cmd_ready   <= enable;
                  done        <= 1'b1;
                  expect_fire <= fire_q;
                  if (win_count != 16'hFFFF) win_count <= win_count + 16'd1;
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ivl_uvm_ovl_win_stim_gen.sv
// Self-checking bench for ivl_uvm_ovl_win_stim_gen (WIDTH=4, GAP_CYCLES=2).
// Cycle k counts negedges after the accepting posedge: k=1 START, k=2..len+1 HOLD,
// k=len+2 END, k=len+3..len+4 GAP, k=len+5 first IDLE cycle with done.
module tb_ivl_uvm_ovl_win_stim_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_data = '0;
   logic [7:0]  cmd_len = '0;
   logic        cmd_inject = 1'b0;
   logic [7:0]  cmd_inject_at = '0;
   logic        start_event;
   logic        end_event;
   logic [3:0]  test_expr;
   logic        busy;
   logic        done;
   logic        expect_fire;
   logic [15:0] win_count;

   ivl_uvm_ovl_win_stim_gen #(
      .WIDTH      (4),
      .GAP_CYCLES (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_data      (cmd_data),
      .cmd_len       (cmd_len),
      .cmd_inject    (cmd_inject),
      .cmd_inject_at (cmd_inject_at),
      .start_event   (start_event),
      .end_event     (end_event),
      .test_expr     (test_expr),
      .busy          (busy),
      .done          (done),
      .expect_fire   (expect_fire),
      .win_count     (win_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] data;
      logic [7:0] len;
      logic       inj;
      logic [7:0] at;
      logic [3:0] flip;    // test_expr once the change is applied
      int         flip_k;  // first cycle carrying the change, 0 = never
      logic       fire;
   } vec_t;

   vec_t vecs[7];
   int   total = 0;
   int   bad = 0;
   int   exp_wins = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"}, start_event, 0);
      check({tag, "_end"}, end_event, 0);
      check({tag, "_texpr"}, test_expr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_fire"}, expect_fire, 0);
      check({tag, "_ready"}, cmd_ready, 0);
      check({tag, "_wins"}, win_count, 0);
   endtask

   // Called at a negedge; returns at the negedge of the START cycle (k=1).
   task automatic start_cmd(input logic [3:0] d, input logic [7:0] l, input logic inj,
                            input logic [7:0] at);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", cmd_ready, 1);
      cmd_data      = d;
      cmd_len       = l;
      cmd_inject    = inj;
      cmd_inject_at = at;
      cmd_valid     = 1'b1;
      @(negedge clk);
      // Scramble the command fields; a busy generator must ignore them.
      cmd_valid     = 1'b0;
      cmd_data      = ~d;
      cmd_len       = l + 8'd3;
      cmd_inject    = ~inj;
      cmd_inject_at = 8'd0;
   endtask

   task automatic run_window(input int idx, input vec_t v, input int drop_k);
      logic [3:0] e;
      int last;
      last = int'(v.len) + 5;
      start_cmd(v.data, v.len, v.inj, v.at);
      for (int k = 1; k <= last; k++) begin
         if (k > 1) @(negedge clk);
         if (k <= int'(v.len) + 2)
            e = (v.flip_k != 0 && k >= v.flip_k) ? v.flip : v.data;
         else
            e = 4'h0;
         check($sformatf("v%0d_k%0d_texpr", idx, k), test_expr, e);
         check($sformatf("v%0d_k%0d_start", idx, k), start_event, k == 1);
         check($sformatf("v%0d_k%0d_end", idx, k), end_event, k == int'(v.len) + 2);
         check($sformatf("v%0d_k%0d_done", idx, k), done, k == last);
         check($sformatf("v%0d_k%0d_fire", idx, k), expect_fire, (k == last) ? v.fire : 1'b0);
         check($sformatf("v%0d_k%0d_busy", idx, k), busy, k < last);
         check($sformatf("v%0d_k%0d_wins", idx, k), win_count,
               (k == last) ? exp_wins + 1 : exp_wins);
         if (k == drop_k) enable = 1'b0;
      end
      exp_wins++;
   endtask

   initial begin
      int starts, ends, dones, overlap, gap_zeros;

      //           data  len    inj   at     flip  flip_k fire
      vecs[0] = '{4'h5, 8'd3, 1'b0, 8'd0, 4'h5, 0, 1'b0};  // clean window
      vecs[1] = '{4'h9, 8'd4, 1'b1, 8'd2, 4'h8, 4, 1'b1};  // change from HOLD 2
      vecs[2] = '{4'h6, 8'd0, 1'b0, 8'd0, 4'h6, 0, 1'b0};  // zero-length hold
      vecs[3] = '{4'h7, 8'd5, 1'b1, 8'd5, 4'h6, 0, 1'b0};  // inject_at == len
      vecs[4] = '{4'hA, 8'd2, 1'b1, 8'd0, 4'hB, 2, 1'b1};  // change from HOLD 0
      vecs[5] = '{4'hF, 8'd1, 1'b1, 8'd0, 4'hE, 2, 1'b1};  // single HOLD, changed
      vecs[6] = '{4'h2, 8'd0, 1'b1, 8'd0, 4'h3, 0, 1'b0};  // inject with len 0

      // Reset state
      repeat (2) @(negedge clk);
      check_all_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", cmd_ready, 1);

      for (int i = 0; i < 7; i++) run_window(i, vecs[i], 0);

      // Back-to-back: valid held high, three windows of len 1, data 3.
      starts = 0; ends = 0; dones = 0; overlap = 0; gap_zeros = 0;
      cmd_data = 4'h3; cmd_len = 8'd1; cmd_inject = 1'b0; cmd_inject_at = 8'd0;
      check("b2b_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (i == 14) cmd_valid = 1'b0;
         starts += int'(start_event);
         ends   += int'(end_event);
         dones  += int'(done);
         if (start_event && end_event) overlap++;
         if (busy && test_expr == 4'h0) gap_zeros++;
      end
      exp_wins += 3;
      check("b2b_starts", starts, 3);
      check("b2b_ends", ends, 3);
      check("b2b_dones", dones, 3);
      check("b2b_overlap", overlap, 0);
      check("b2b_gap_zeros", gap_zeros, 6);
      check("b2b_wins", win_count, exp_wins);

      // Enable drop during HOLD: window completes, ready stays low until enable returns.
      run_window(10, '{4'hC, 8'd4, 1'b0, 8'd0, 4'hC, 0, 1'b0}, 3);
      check("endrop_ready_done", cmd_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("endrop_ready_low%0d", i), cmd_ready, 0);
      end
      enable = 1'b1;
      @(negedge clk);
      check("endrop_ready_back", cmd_ready, 1);

      // Reset at HOLD index 1: first clear the count so it reads 0 after.
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      exp_wins = 0;
      @(negedge clk);
      start_cmd(4'hD, 8'd4, 1'b1, 8'd0);
      repeat (2) @(negedge clk);
      check("midhold_texpr_pre", test_expr, 4'hC);
      #1 rst_n = 1'b0;
      #1 check_all_zero("midhold_async");
      repeat (2) begin
         @(negedge clk);
         check("midhold_no_done", done, 0);
         check("midhold_wins", win_count, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("midhold_ready", cmd_ready, 1);
      run_window(20, vecs[1], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
